pwm_servo_bank: RTL and testbench

//  Multi-channel servo PWM generator: one shared period counter drives N_CH duty comparators.

---
 rtl/pwm_servo_bank_pkg.sv | 17 +
 rtl/pwm_servo_bank_ch.sv | 50 +++++
 rtl/pwm_servo_bank.sv | 105 ++++++++++
 tb/tb_pwm_servo_bank.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_servo_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_servo_bank_pkg
//  Description : Shared defaults and limits for the servo PWM bank.
//  Revision    : 1.0
// ============================================================================
package pwm_servo_bank_pkg;

    // 20 ms frame and 1.5 ms centre pulse at a 100 MHz clock
    localparam int unsigned c_DEF_PERIOD = 2000000;
    localparam int unsigned c_DEF_DUTY   = 150000;

    // Shortest period that still leaves one high and one low cycle
    localparam int unsigned c_MIN_PERIOD = 2;

endpackage : pwm_servo_bank_pkg
`default_nettype wire

// File: rtl/pwm_servo_bank_ch.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_servo_bank_ch
//  Description : One PWM channel: duty shadow/active pair and registered compare.
//  Revision    : 1.0
// ============================================================================
module pwm_servo_bank_ch
    import pwm_servo_bank_pkg::*;
#(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned DEF_DUTY = c_DEF_DUTY
) (
    input  logic             clk,
    input  logic             res,
    input  logic             load,
    input  logic             commit,
    input  logic             out_en,
    input  logic [CNT_W-1:0] duty_in,
    input  logic [CNT_W-1:0] cnt,
    output logic             pwm
);

    localparam logic [CNT_W-1:0] c_DEF_DUTY_W = CNT_W'(DEF_DUTY);

    logic [CNT_W-1:0] r_duty_s;
    logic [CNT_W-1:0] r_duty_a;
    logic             r_pwm;

    // Active duty takes the shadow as it stood before this edge, so a load
    // landing on a boundary is held back until the following boundary.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_duty_s <= c_DEF_DUTY_W;
            r_duty_a <= c_DEF_DUTY_W;
            r_pwm    <= 1'b0;
        end else begin
            if (load) begin
                r_duty_s <= duty_in;
            end
            if (commit) begin
                r_duty_a <= r_duty_s;
            end
            r_pwm <= out_en && (cnt < r_duty_a);
        end
    end

    assign pwm = r_pwm;

endmodule : pwm_servo_bank_ch
`default_nettype wire

// File: rtl/pwm_servo_bank.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_servo_bank
//  Description : Multi-channel servo PWM with one shared period counter and
//                shadowed period/duty registers committed at period boundaries.
//  Revision    : 1.0
// ============================================================================
module pwm_servo_bank
    import pwm_servo_bank_pkg::*;
#(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned DEF_PERIOD = c_DEF_PERIOD,
    parameter int unsigned DEF_DUTY   = c_DEF_DUTY
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  enable,
    input  logic [CNT_W-1:0]      period_i,
    input  logic [N_CH*CNT_W-1:0] duty_i,
    input  logic                  load_i,
    output logic                  pending_o,
    output logic                  sync_o,
    output logic [N_CH-1:0]       pwm_o
);

    localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_MIN_PER = CNT_W'(c_MIN_PERIOD);
    localparam logic [CNT_W-1:0] c_DEF_PER = CNT_W'(DEF_PERIOD);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_per_s;
    logic [CNT_W-1:0] r_per_a;
    logic             r_pending;
    logic             r_run;
    logic             r_sync;

    logic [CNT_W-1:0] w_per_in;
    logic             w_last;
    logic             w_boundary;
    logic             w_commit;
    logic             w_out_en;

    assign w_per_in   = (period_i < c_MIN_PER) ? c_MIN_PER : period_i;
    assign w_last     = (r_cnt == (r_per_a - c_ONE));
    // r_run low means the previous edge was idle: this edge restarts the frame
    assign w_boundary = enable && (!r_run || w_last);
    assign w_commit   = w_boundary && r_pending;
    // The counter value only describes a live frame once an enabled edge has set it
    assign w_out_en   = enable && r_run;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_cnt     <= '0;
            r_per_s   <= c_DEF_PER;
            r_per_a   <= c_DEF_PER;
            r_pending <= 1'b0;
            r_run     <= 1'b0;
            r_sync    <= 1'b0;
        end else begin
            r_run  <= enable;
            r_sync <= w_out_en && (r_cnt == '0);

            if (!enable || w_boundary) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_ONE;
            end

            if (load_i) begin
                r_per_s   <= w_per_in;
                r_pending <= 1'b1;
            end else if (w_commit) begin
                r_pending <= 1'b0;
            end

            if (w_commit) begin
                r_per_a <= r_per_s;
            end
        end
    end

    generate
        for (genvar k = 0; k < N_CH; k++) begin : g_ch
            pwm_servo_bank_ch #(
                .CNT_W    (CNT_W),
                .DEF_DUTY (DEF_DUTY)
            ) u_ch (
                .clk     (clk),
                .res     (res),
                .load    (load_i),
                .commit  (w_commit),
                .out_en  (w_out_en),
                .duty_in (duty_i[k*CNT_W +: CNT_W]),
                .cnt     (r_cnt),
                .pwm     (pwm_o[k])
            );
        end
    endgenerate

    assign pending_o = r_pending;
    assign sync_o    = r_sync;

endmodule : pwm_servo_bank
`default_nettype wire

// File: tb/tb_pwm_servo_bank.sv
`default_nettype none
// Directed bench for pwm_servo_bank: 2 channels, 8-bit counter, period 10, duty 3.
module tb_pwm_servo_bank;

    logic        clk = 1'b0;
    logic        res;
    logic        enable;
    logic [7:0]  period_i;
    logic [15:0] duty_i;
    logic        load_i;
    logic        pending_o;
    logic        sync_o;
    logic [1:0]  pwm_o;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    pwm_servo_bank #(
        .N_CH       (2),
        .CNT_W      (8),
        .DEF_PERIOD (10),
        .DEF_DUTY   (3)
    ) dut (
        .clk       (clk),
        .res       (res),
        .enable    (enable),
        .period_i  (period_i),
        .duty_i    (duty_i),
        .load_i    (load_i),
        .pending_o (pending_o),
        .sync_o    (sync_o),
        .pwm_o     (pwm_o)
    );

    // Expected outputs for a cycle whose counter value was c
    function automatic logic [1:0] exp_pwm(input int c, input int d0, input int d1);
        return {(c < d1) ? 1'b1 : 1'b0, (c < d0) ? 1'b1 : 1'b0};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        res = 1'b1; enable = 1'b0; load_i = 1'b0; period_i = '0; duty_i = '0;
        #1;
        total++;
        if (pwm_o !== 2'b00 || sync_o !== 1'b0 || pending_o !== 1'b0)
            $display("FAIL reset_state: got pwm=%b sync=%b pend=%b, expected 00/0/0", pwm_o, sync_o, pending_o);
        else passed++;
        tick(); tick();
        res = 1'b0;
        enable = 1'b1;
        tick();
        total++;
        if (pwm_o !== 2'b00 || sync_o !== 1'b0)
            $display("FAIL first_enable_edge: got pwm=%b sync=%b, expected 00/0", pwm_o, sync_o);
        else passed++;
    endtask

    task automatic test_default_frames;
        logic [1:0] e;
        for (int i = 0; i < 20; i++) begin
            tick();
            e = exp_pwm(i % 10, 3, 3);
            total++;
            if (pwm_o !== e || sync_o !== ((i % 10) == 0) || pending_o !== 1'b0)
                $display("FAIL default_frame i=%0d: got pwm=%b sync=%b pend=%b, expected %b/%b/0",
                         i, pwm_o, sync_o, pending_o, e, ((i % 10) == 0));
            else passed++;
        end
    endtask

    task automatic test_load_midperiod;
        logic [1:0] e;
        logic       ep;
        for (int c = 0; c < 4; c++) begin
            tick();
            total++;
            if (pwm_o !== exp_pwm(c, 3, 3) || pending_o !== 1'b0)
                $display("FAIL pre_load c=%0d: got pwm=%b pend=%b, expected %b/0", c, pwm_o, pending_o, exp_pwm(c, 3, 3));
            else passed++;
        end
        period_i = 8'd12; duty_i = {8'd0, 8'd6}; load_i = 1'b1;
        for (int c = 4; c < 10; c++) begin
            tick();
            load_i = 1'b0;
            ep = (c != 9);
            e  = exp_pwm(c, 3, 3);
            total++;
            if (pwm_o !== e || pending_o !== ep)
                $display("FAIL load_old_period c=%0d: got pwm=%b pend=%b, expected %b/%b", c, pwm_o, pending_o, e, ep);
            else passed++;
        end
        for (int c = 0; c < 12; c++) begin
            tick();
            e = exp_pwm(c, 6, 0);
            total++;
            if (pwm_o !== e || sync_o !== (c == 0) || pending_o !== 1'b0)
                $display("FAIL new_period12 c=%0d: got pwm=%b sync=%b pend=%b, expected %b/%b/0",
                         c, pwm_o, sync_o, pending_o, e, (c == 0));
            else passed++;
        end
    endtask

    task automatic test_clamp_and_min_period;
        logic [1:0] e;
        logic       ep;
        period_i = 8'd12; duty_i = {8'd255, 8'd12}; load_i = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            load_i = 1'b0;
            ep = (c != 11);
            e  = exp_pwm(c, 6, 0);
            total++;
            if (pwm_o !== e || pending_o !== ep)
                $display("FAIL clamp_old_period c=%0d: got pwm=%b pend=%b, expected %b/%b", c, pwm_o, pending_o, e, ep);
            else passed++;
        end
        for (int i = 0; i < 24; i++) begin
            tick();
            total++;
            if (pwm_o !== 2'b11 || sync_o !== ((i % 12) == 0))
                $display("FAIL const_high i=%0d: got pwm=%b sync=%b, expected 11/%b", i, pwm_o, sync_o, ((i % 12) == 0));
            else passed++;
        end
        period_i = 8'd0; duty_i = {8'd0, 8'd1}; load_i = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            load_i = 1'b0;
            ep = (c != 11);
            total++;
            if (pwm_o !== 2'b11 || pending_o !== ep)
                $display("FAIL minper_old_period c=%0d: got pwm=%b pend=%b, expected 11/%b", c, pwm_o, pending_o, ep);
            else passed++;
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            e = exp_pwm(i % 2, 1, 0);
            total++;
            if (pwm_o !== e || sync_o !== ((i % 2) == 0))
                $display("FAIL min_period i=%0d: got pwm=%b sync=%b, expected %b/%b", i, pwm_o, sync_o, e, ((i % 2) == 0));
            else passed++;
        end
    endtask

    task automatic test_load_on_wrap;
        logic [1:0] e;
        tick();
        total++;
        if (pwm_o !== 2'b01 || sync_o !== 1'b1 || pending_o !== 1'b0)
            $display("FAIL wrap_pre: got pwm=%b sync=%b pend=%b, expected 01/1/0", pwm_o, sync_o, pending_o);
        else passed++;
        period_i = 8'd10; duty_i = {8'd2, 8'd4}; load_i = 1'b1;
        tick();
        load_i = 1'b0;
        total++;
        if (pwm_o !== 2'b00 || pending_o !== 1'b1)
            $display("FAIL wrap_load_edge: got pwm=%b pend=%b, expected 00/1", pwm_o, pending_o);
        else passed++;
        tick();
        total++;
        if (pwm_o !== 2'b01 || sync_o !== 1'b1 || pending_o !== 1'b1)
            $display("FAIL wrap_held_c0: got pwm=%b sync=%b pend=%b, expected 01/1/1", pwm_o, sync_o, pending_o);
        else passed++;
        tick();
        total++;
        if (pwm_o !== 2'b00 || pending_o !== 1'b0)
            $display("FAIL wrap_commit_c1: got pwm=%b pend=%b, expected 00/0", pwm_o, pending_o);
        else passed++;
        for (int c = 0; c < 10; c++) begin
            tick();
            e = exp_pwm(c, 4, 2);
            total++;
            if (pwm_o !== e || sync_o !== (c == 0))
                $display("FAIL wrap_new_period c=%0d: got pwm=%b sync=%b, expected %b/%b", c, pwm_o, sync_o, e, (c == 0));
            else passed++;
        end
    endtask

    task automatic test_disable;
        logic [1:0] e;
        tick(); tick();
        total++;
        if (pwm_o !== 2'b11)
            $display("FAIL dis_pre_high: got pwm=%b, expected 11", pwm_o);
        else passed++;
        enable = 1'b0;
        tick();
        total++;
        if (pwm_o !== 2'b00 || sync_o !== 1'b0)
            $display("FAIL dis_outputs_low: got pwm=%b sync=%b, expected 00/0", pwm_o, sync_o);
        else passed++;
        period_i = 8'd6; duty_i = {8'd6, 8'd3}; load_i = 1'b1;
        tick();
        load_i = 1'b0;
        tick();
        total++;
        if (pwm_o !== 2'b00 || pending_o !== 1'b1)
            $display("FAIL dis_load: got pwm=%b pend=%b, expected 00/1", pwm_o, pending_o);
        else passed++;
        enable = 1'b1;
        tick();
        total++;
        if (pwm_o !== 2'b00 || sync_o !== 1'b0 || pending_o !== 1'b0)
            $display("FAIL reenable_edge: got pwm=%b sync=%b pend=%b, expected 00/0/0", pwm_o, sync_o, pending_o);
        else passed++;
        for (int i = 0; i < 12; i++) begin
            tick();
            e = exp_pwm(i % 6, 3, 6);
            total++;
            if (pwm_o !== e || sync_o !== ((i % 6) == 0))
                $display("FAIL reenable_period i=%0d: got pwm=%b sync=%b, expected %b/%b", i, pwm_o, sync_o, e, ((i % 6) == 0));
            else passed++;
        end
    endtask

    task automatic test_async_reset;
        logic [1:0] e;
        period_i = 8'd8; duty_i = {8'd1, 8'd1}; load_i = 1'b1;
        tick();
        load_i = 1'b0;
        tick();
        total++;
        if (pwm_o !== 2'b11 || pending_o !== 1'b1)
            $display("FAIL rst_pre: got pwm=%b pend=%b, expected 11/1", pwm_o, pending_o);
        else passed++;
        #3;
        res = 1'b1;
        #1;
        total++;
        if (pwm_o !== 2'b00 || sync_o !== 1'b0 || pending_o !== 1'b0)
            $display("FAIL async_reset: got pwm=%b sync=%b pend=%b, expected 00/0/0", pwm_o, sync_o, pending_o);
        else passed++;
        #1;
        res = 1'b0;
        tick();
        total++;
        if (pwm_o !== 2'b00 || pending_o !== 1'b0)
            $display("FAIL post_reset_edge: got pwm=%b pend=%b, expected 00/0", pwm_o, pending_o);
        else passed++;
        for (int c = 0; c < 10; c++) begin
            tick();
            e = exp_pwm(c, 3, 3);
            total++;
            if (pwm_o !== e || sync_o !== (c == 0) || pending_o !== 1'b0)
                $display("FAIL post_reset_defaults c=%0d: got pwm=%b sync=%b pend=%b, expected %b/%b/0",
                         c, pwm_o, sync_o, pending_o, e, (c == 0));
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_default_frames();
        test_load_midperiod();
        test_clamp_and_min_period();
        test_load_on_wrap();
        test_disable();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_pwm_servo_bank
`default_nettype wire
